rv_lsu: RTL
===========

Name: rv_lsu

Overview:
- Load/store unit: the initiator side of the single-port word RAM on the RV32 core's data path.
- Accepts byte, half and word load/store requests from the execute stage and drives the RAM address, write and datain ports.
- Captures the RAM's registered read data, then sign- or zero-extends it for loads.
- Implements sub-word stores as read-modify-write, because the RAM has no byte enables.

Parameters:
- DEPTH_LOG2, 10, log2 of RAM word count; mem_address = zero-extended req_addr[DEPTH_LOG2+1:2]; upper address bits alias.

Ports:
- clk  in  1  clock, rising edge
- clr_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request offered
- req_ready  out  1  high only in IDLE; transfer = req_valid & req_ready at a rising edge
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads: 1 = zero-extend (LBU/LHU), 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  1  qualifies resp_valid; access was rejected
- mem_address  out  32  RAM word index
- mem_write  out  1  RAM write strobe
- mem_datain  out  32  RAM write data
- mem_dataout  in  32  RAM read data, valid the cycle after an address is presented with mem_write=0

Behaviour:
- Request fields are captured on transfer. Inputs are ignored outside IDLE.
- States: IDLE, RD, MRG, WR, RSP.
- Transitions:
  - Load: IDLE→RD→MRG→RSP→IDLE.
  - Word store: IDLE→WR→RSP→IDLE.
  - Byte/half store: IDLE→RD→MRG→WR→RSP→IDLE.
  - Error: IDLE→RSP (resp_err=1, no RAM access).
- RD: mem_address = word index, mem_write=0.
- MRG, load path: byte lane (addr[1:0]) or half lane (addr[1]) is selected from mem_dataout and extended per req_unsigned into resp_rdata.
- MRG, store path: req_wdata lane(s) are merged into the mem_dataout word; the merged word is registered.
- WR: mem_write=1 for exactly one cycle; mem_datain = merged word or req_wdata.
- RSP: resp_valid=1 for one cycle; resp_rdata and resp_err are held stable and zeroed on leaving RSP.
- Latency from transfer edge to resp_valid:
  - load: 3 cycles
  - word store: 2 cycles
  - sub-word store: 4 cycles
  - error: 1 cycle
- Back-to-back: a new transfer is possible the cycle after RSP (IDLE). No pipelining, one request outstanding.
- mem_write and req_ready decode from state only. mem_address and mem_datain hold their last values outside RD and WR.
- req_size=11 always yields resp_err.
- Reset (clr_n low, at any time, including mid-read-modify-write):
  - state→IDLE
  - resp_valid, resp_err, resp_rdata, mem_write, mem_address, mem_datain all 0
  - req_ready=1
  - an in-flight store is abandoned; the RAM word keeps its old or fully-written value, never partially merged.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: half with addr[0]=1, or word with addr[1:0]≠00, gives an error response with no RAM access.
- Undefined: misaligned low address bits are forced to zero (half: addr[0]; word: addr[1:0]) and the access proceeds; resp_err is only for size 11.

Decomposition:
- Package rv_mem_pkg:
  - size encodings SZ_B, SZ_H, SZ_W
  - lsu state enum
  - DEPTH_LOG2 default
- Sub-module rv_lsu_align (combinational) provides:
  - load-lane extract/extend: lane select, size, unsigned → 32-bit result
  - store merge: old word, wdata, addr[1:0], size → new word

Test Plan:
- Word store then load: store 0xDEADBEEF @0x10, load word @0x10 → mem_write pulses once with mem_address=4; load resp_rdata=0xDEADBEEF, 3 cycles after transfer.
- Byte store RMW: word @0x20 = 0x11223344, store byte 0xAA @0x22 → mem_datain=0x11AA3344 in WR; a later load word returns 0x11AA3344.
- Sign/zero extension: word @0x30 = 0x0000F080:
  - LB @0x30 → 0xFFFFFF80
  - LBU @0x30 → 0x00000080
  - LH @0x30 → 0xFFFFF080
  - LHU @0x30 → 0x0000F080
- Misalignment: load word @0x41.
  - LSU_MISALIGN_TRAP_EN defined → resp_err=1 one cycle after transfer, mem_write never asserted.
  - Undefined → data of word @0x40 returned, resp_err=0.
- Reset mid-RMW: byte store @0x50, drop clr_n in MRG → mem_write never asserts, all outputs 0, req_ready=1; word @0x50 unchanged.
- Illegal size and back-to-back: size=11 → resp_err=1, resp_rdata=0; a second request held valid is accepted the cycle after RSP.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// Shared encodings for the RV32 data-side memory path: access sizes,
// load/store unit state encoding and the captured request record.
package rv_mem_pkg;

    localparam int DEPTH_LOG2_DEF = 10;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    typedef enum logic [2:0] {
        LSU_IDLE = 3'd0,
        LSU_RD   = 3'd1,
        LSU_MRG  = 3'd2,
        LSU_WR   = 3'd3,
        LSU_RSP  = 3'd4
    } lsu_state_e;

    // Only the byte offset is kept; the word index goes straight to mem_address.
    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  lo;
        logic [31:0] wdata;
    } lsu_req_t;

endpackage

// File: rtl/rv_lsu_align.sv
// Byte-lane datapath for the LSU: load lane extract/extend and sub-word
// store merge into the old RAM word (the RAM has no byte enables).
module rv_lsu_align
    import rv_mem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  lo,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);

    localparam int NUM_LANES = 4;

    logic [7:0]  b_sel;
    logic [15:0] h_sel;
    logic [NUM_LANES-1:0][7:0] merged;

    always_comb begin
        b_sel   = old_word[{lo, 3'b000} +: 8];
        h_sel   = old_word[{lo[1], 4'b0000} +: 16];
        ld_data = old_word;
        case (size)
            SZ_B:    ld_data = {{24{~uns & b_sel[7]}}, b_sel};
            SZ_H:    ld_data = {{16{~uns & h_sel[15]}}, h_sel};
            default: ld_data = old_word;
        endcase
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        localparam logic [1:0] LN = 2'(i);
        logic       hit;
        logic [7:0] src;

        // Half stores place wdata[7:0] in the even lane, wdata[15:8] in the odd one.
        always_comb begin
            hit = 1'b1;
            src = wdata[8*i +: 8];
            case (size)
                SZ_B: begin
                    hit = (lo == LN);
                    src = wdata[7:0];
                end
                SZ_H: begin
                    hit = (lo[1] == LN[1]);
                    src = wdata[8*(i%2) +: 8];
                end
                default: ;
            endcase
        end

        assign merged[i] = hit ? src : old_word[8*i +: 8];
    end

    assign st_word = merged;

endmodule

// File: rtl/rv_lsu.sv
// Load/store unit driving a single-port registered word RAM; sub-word stores
// are read-modify-write. Optional LSU_MISALIGN_TRAP_EN rejects misaligned half/word.
module rv_lsu
    import rv_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic        mem_write,
    output logic [31:0] mem_datain,
    input  logic [31:0] mem_dataout
);

    localparam logic [2:0] S_IDLE = LSU_IDLE;
    localparam logic [2:0] S_RD   = LSU_RD;
    localparam logic [2:0] S_MRG  = LSU_MRG;
    localparam logic [2:0] S_WR   = LSU_WR;
    localparam logic [2:0] S_RSP  = LSU_RSP;

    logic [2:0]  state;
    lsu_req_t    req_q;
    logic        misal;
    logic        bad;
    logic [1:0]  lo_in;
    logic [31:0] widx;
    logic [31:0] ld_data;
    logic [31:0] st_word;
    logic        unused_addr_hi;

    assign req_ready  = (state == S_IDLE);
    assign mem_write  = (state == S_WR);
    assign resp_valid = (state == S_RSP);

    // Upper address bits alias onto the RAM.
    assign widx           = 32'(req_addr[DEPTH_LOG2+1:2]);
    assign unused_addr_hi = ^req_addr[31:DEPTH_LOG2+2];

`ifdef LSU_MISALIGN_TRAP_EN
    assign misal = ((req_size == SZ_H) && req_addr[0]) ||
                   ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
    assign lo_in = req_addr[1:0];
`else
    assign misal = 1'b0;
    always_comb begin
        lo_in = req_addr[1:0];
        case (req_size)
            SZ_H:    lo_in = {req_addr[1], 1'b0};
            SZ_W:    lo_in = 2'b00;
            default: lo_in = req_addr[1:0];
        endcase
    end
`endif

    assign bad = (req_size == SZ_X) || misal;

    rv_lsu_align u_align (
        .old_word (mem_dataout),
        .wdata    (req_q.wdata),
        .lo       (req_q.lo),
        .size     (req_q.size),
        .uns      (req_q.uns),
        .ld_data  (ld_data),
        .st_word  (st_word)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state       <= S_IDLE;
            req_q       <= '0;
            mem_address <= '0;
            mem_datain  <= '0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    req_q <= '{write: req_write, size: req_size, uns: req_unsigned,
                               lo: lo_in, wdata: req_wdata};
                    if (bad) begin
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                        state      <= S_RSP;
                    end else begin
                        mem_address <= widx;
                        if (req_write && (req_size == SZ_W)) begin
                            mem_datain <= req_wdata;
                            state      <= S_WR;
                        end else begin
                            state <= S_RD;
                        end
                    end
                end
                S_RD:  state <= S_MRG;
                // mem_dataout carries the word addressed during RD.
                S_MRG: if (req_q.write) begin
                    mem_datain <= st_word;
                    state      <= S_WR;
                end else begin
                    resp_rdata <= ld_data;
                    state      <= S_RSP;
                end
                S_WR:  state <= S_RSP;
                S_RSP: begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
